// File: rtl/unified_mem_ctrl.sv
// rtl/unified_mem_ctrl.sv - unified instruction/data memory with two-port arbiter
// Data port has priority; a starvation counter forces an instruction grant.
module unified_mem_ctrl #(
  parameter int WORDS        = 1024,
  parameter int DATA_W       = 32,
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [31:0]         i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [31:0]         d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready
);
  localparam int BE  = DATA_W / 8;
  localparam int OFF = (BE > 1) ? $clog2(BE) : 0;
  localparam int AW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int SW  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              sel_data_q, sel_data_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              hit_q, hit_d;
  logic [BE-1:0]     we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d, d_ready_q, d_ready_d;

  logic [DATA_W-1:0] mem [WORDS];
  logic [31:0]       i_idx, d_idx, g_idx;
  logic              grant_data, access, mem_wr;
  logic [DATA_W-1:0] rd_word;

  assign i_idx      = i_addr >> OFF;
  assign d_idx      = d_addr >> OFF;
  assign grant_data = d_req && !(i_req && (starve_q == SW'(STARVE_LIMIT)));
  assign g_idx      = grant_data ? d_idx : i_idx;
  assign access     = (state_q == S_WAIT) && (cnt_q == 4'd0);
  // Out-of-range accesses read as zero and never touch the array.
  assign rd_word    = hit_q ? mem[idx_q] : '0;
  assign mem_wr     = access && sel_data_q && hit_q && (we_q != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    sel_data_d = sel_data_q;
    idx_d      = idx_q;
    hit_d      = hit_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_ready_d  = 1'b0;
    d_ready_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          state_d    = S_WAIT;
          cnt_d      = 4'(LATENCY);
          sel_data_d = grant_data;
          idx_d      = g_idx[AW-1:0];
          hit_d      = g_idx < 32'(WORDS);
          we_d       = grant_data ? d_we : '0;
          wdata_d    = d_wdata;
          if (grant_data && i_req)
            starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
          else
            starve_d = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (sel_data_q) begin
            d_rdata_d = rd_word;
            d_ready_d = 1'b1;
          end else begin
            i_rdata_d = rd_word;
            i_ready_d = 1'b1;
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      sel_data_q <= 1'b0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      we_q       <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_ready_q  <= 1'b0;
      d_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      sel_data_q <= sel_data_d;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_ready_q  <= i_ready_d;
      d_ready_q  <= d_ready_d;
    end
  end

  // Array is not reset; a write lands only on its access edge.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < BE; b++) begin
        if (we_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign i_rdata = i_rdata_q;
  assign i_ready = i_ready_q;
  assign d_rdata = d_rdata_q;
  assign d_ready = d_ready_q;
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// tb/tb_unified_mem_ctrl.sv - self-checking bench for unified_mem_ctrl
// Two instances (LATENCY 1 and 3) share stimulus; the idle one is held in reset.
module tb_unified_mem_ctrl;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst1, rst3;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_we;
  logic [31:0] i_rdata1, d_rdata1, i_rdata3, d_rdata3;
  logic        i_ready1, d_ready1, i_ready3, d_ready3;

  always #5 clk = ~clk;

  unified_mem_ctrl #(.WORDS(1024), .DATA_W(32), .LATENCY(1), .STARVE_LIMIT(STARVE)) u_dut (
    .clk(clk), .rst(rst1),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata1), .i_ready(i_ready1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata1), .d_ready(d_ready1)
  );

  unified_mem_ctrl #(.WORDS(1024), .DATA_W(32), .LATENCY(3), .STARVE_LIMIT(STARVE)) u_dut3 (
    .clk(clk), .rst(rst3),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata3), .i_ready(i_ready3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata3), .d_ready(d_ready3)
  );

  bit          sel3 = 1'b0;
  int          lat  = 1;
  logic        o_i_ready, o_d_ready;
  logic [31:0] o_i_rdata, o_d_rdata;
  assign o_i_ready = sel3 ? i_ready3 : i_ready1;
  assign o_d_ready = sel3 ? d_ready3 : d_ready1;
  assign o_i_rdata = sel3 ? i_rdata3 : i_rdata1;
  assign o_d_rdata = sel3 ? d_rdata3 : d_rdata1;

  int total_cnt = 0, pass_cnt = 0, fail_cnt = 0, coincide = 0;
  logic [31:0] ref_mem [longint];
  logic [31:0] exp_i, exp_d;

  always @(negedge clk)
    if ((i_ready1 && d_ready1) || (i_ready3 && d_ready3)) coincide++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint key_of(input logic [31:0] addr);
    return longint'(addr >> 2) + (sel3 ? 64'h1_0000_0000 : 64'h0);
  endfunction

  // One complete transaction on a single port, starting at a negedge with the controller idle.
  task automatic txn(input bit isd, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wdata, input string tag);
    longint      idx = longint'(addr >> 2);
    longint      key = key_of(addr);
    logic [31:0] exp_rd, neww;
    int          n = 0;
    bit          seen = 0;
    exp_rd = (idx < 1024 && ref_mem.exists(key)) ? ref_mem[key] : 32'h0;
    if (isd) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (isd ? o_d_ready : o_i_ready) seen = 1;
    end
    check({tag, " ready"}, 32'(seen), 32'd1);
    check({tag, " latency"}, n, lat + 2);
    if (isd) begin
      check({tag, " d_rdata"}, o_d_rdata, exp_rd);
      check({tag, " i_rdata held"}, o_i_rdata, exp_i);
      exp_d = exp_rd;
      if (idx < 1024 && we != 4'h0) begin
        neww = exp_rd;
        for (int b = 0; b < 4; b++) if (we[b]) neww[8*b +: 8] = wdata[8*b +: 8];
        ref_mem[key] = neww;
      end
    end else begin
      check({tag, " i_rdata"}, o_i_rdata, exp_rd);
      check({tag, " d_rdata held"}, o_d_rdata, exp_d);
      exp_i = exp_rd;
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 4'h0;
    @(negedge clk);
    check({tag, " ready pulse"}, {30'h0, o_i_ready, o_d_ready}, 32'h0);
  endtask

  initial begin
    int          n;
    bit          seen, got_d;
    logic [31:0] a;
    rst1 = 1'b0; rst3 = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 4'h0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    exp_i = '0; exp_d = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", {o_i_rdata ^ o_d_rdata, 30'h0, o_i_ready, o_d_ready}, 64'h0);
    check("reset i_rdata", o_i_rdata, 32'h0);
    check("reset d_rdata", o_d_rdata, 32'h0);
    rst1 = 1'b1;
    @(negedge clk);

    // Write then back-to-back read
    txn(1, 4'hF, 32'h10, 32'hDEADBEEF, "t1 write");
    txn(1, 4'h0, 32'h10, 32'h0, "t1 read");
    check("t1 value", o_d_rdata, 32'hDEADBEEF);

    // Byte enables
    txn(1, 4'hF, 32'h20, 32'h11223344, "t2 full");
    txn(1, 4'b0101, 32'h20, 32'hAABBCCDD, "t2 masked");
    check("t2 pre-write", o_d_rdata, 32'h11223344);
    txn(1, 4'h0, 32'h20, 32'h0, "t2 read");
    check("t2 merged", o_d_rdata, 32'h11BB33DD);

    // Instruction fetch
    txn(1, 4'hF, 32'h14, 32'h00500093, "t4 preload");
    txn(0, 4'h0, 32'h14, 32'h0, "t4 fetch");
    check("t4 value", o_i_rdata, 32'h00500093);

    // Contention: both requests held; every STARVE+1-th grant goes to instruction
    i_addr = 32'h14; d_addr = 32'h10; d_we = 4'h0;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 2 * (STARVE + 1); k++) begin
      n = 0; seen = 0; got_d = 0;
      while (!seen && n < 50) begin
        @(negedge clk);
        n++;
        if (o_d_ready || o_i_ready) begin seen = 1; got_d = o_d_ready; end
      end
      check($sformatf("t3 grant%0d spacing", k), n, (k == 0) ? lat + 2 : lat + 3);
      check($sformatf("t3 grant%0d port_is_data", k), 32'(got_d),
            32'((k % (STARVE + 1)) != STARVE));
      if (got_d) check($sformatf("t3 grant%0d d_rdata", k), o_d_rdata, 32'hDEADBEEF);
      else       check($sformatf("t3 grant%0d i_rdata", k), o_i_rdata, 32'h00500093);
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    exp_i = 32'h00500093; exp_d = 32'hDEADBEEF;

    // Out-of-range index must not alias onto word 0
    txn(1, 4'hF, 32'h0, 32'h0BADC0DE, "t5 word0");
    txn(1, 4'hF, 32'h1000, 32'hFFFFFFFF, "t5 oor write");
    txn(1, 4'h0, 32'h1000, 32'h0, "t5 oor read");
    check("t5 oor zero", o_d_rdata, 32'h0);
    txn(1, 4'h0, 32'h0, 32'h0, "t5 word0 read");
    check("t5 word0 kept", o_d_rdata, 32'h0BADC0DE);

    // Randomised traffic over a small window plus occasional out-of-range
    for (int w = 0; w < 16; w++) txn(1, 4'hF, 32'((32 + w) << 2), $urandom, "rnd preload");
    for (int r = 0; r < 24; r++) begin
      a = 32'(((32 + $urandom_range(0, 15)) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 32'h4000 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) txn(1, 4'($urandom_range(0, 15)), a, $urandom, "rnd data");
      else                           txn(0, 4'h0, a, 32'h0, "rnd instr");
    end

    // Reset in the middle of a LATENCY=3 write
    rst1 = 1'b0; rst3 = 1'b1; sel3 = 1'b1; lat = 3;
    exp_i = '0; exp_d = '0;
    @(negedge clk);
    txn(1, 4'hF, 32'h40, 32'h12345678, "t6 preload");
    d_req = 1'b1; d_we = 4'hF; d_addr = 32'h40; d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    check("t6 rst i_ready", 32'(o_i_ready), 32'h0);
    check("t6 rst d_ready", 32'(o_d_ready), 32'h0);
    check("t6 rst i_rdata", o_i_rdata, 32'h0);
    check("t6 rst d_rdata", o_d_rdata, 32'h0);
    d_req = 1'b0; d_we = 4'h0;
    exp_d = '0;
    repeat (2) @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    txn(1, 4'h0, 32'h40, 32'h0, "t6 read");
    check("t6 not committed", o_d_rdata, 32'h12345678);

    check("ready coincidence", coincide, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
